// File: rtl/glyph_matrix_scanner_pkg.sv
// Shared constants and types for the glyph matrix scanner.
package glyph_matrix_scanner_pkg;

    localparam int unsigned NUM_ROWS   = 5;
    localparam int unsigned GLYPH_COLS = 3;
    localparam int unsigned GLYPH_W    = 15;
    // Two glyphs plus the dark gap column between them.
    localparam int unsigned COL_W      = 2 * GLYPH_COLS + 1;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } state_t;

    // One-hot row drive; bit 0 is the top row, out-of-range indices give all zeros.
    function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [2:0] idx);
        logic [NUM_ROWS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (idx == 3'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/glyph_matrix_scanner_if.sv
// Glyph inputs and LED matrix drive outputs of the scanner.
interface glyph_matrix_scanner_if;
    import glyph_matrix_scanner_pkg::*;

    logic                enable;
    logic [GLYPH_W-1:0]  letter_left;
    logic [GLYPH_W-1:0]  letter_right;
    logic [NUM_ROWS-1:0] row_sel;
    logic [COL_W-1:0]    col;
    logic                frame_start;

    // master supplies the glyphs and enable, slave is the scanner itself
    modport master (
        output enable,
        output letter_left,
        output letter_right,
        input  row_sel,
        input  col,
        input  frame_start
    );

    modport slave (
        input  enable,
        input  letter_left,
        input  letter_right,
        output row_sel,
        output col,
        output frame_start
    );

endinterface

// File: rtl/glyph_matrix_scanner_row.sv
// Picks the three column bits of one row out of a 3x5 glyph bitmap.
module glyph_row_select
    import glyph_matrix_scanner_pkg::*;
(
    input  logic [GLYPH_W-1:0]    glyph,
    input  logic [2:0]            row,
    output logic [GLYPH_COLS-1:0] cols
);

    // Row 0 sits in the top bits of the bitmap; bit 0 of each slice is the leftmost column.
    always_comb begin
        cols = '0;
        case (row)
            3'd0:    cols = glyph[14:12];
            3'd1:    cols = glyph[11:9];
            3'd2:    cols = glyph[8:6];
            3'd3:    cols = glyph[5:3];
            3'd4:    cols = glyph[2:0];
            default: cols = '0;
        endcase
    end

endmodule

// File: rtl/glyph_matrix_scanner.sv
// Row-multiplexed driver for a 5x7 LED matrix showing two 3x5 glyphs.
// Each row is preceded by a dark interval; glyphs are latched once per frame.
module glyph_matrix_scanner
    import glyph_matrix_scanner_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES   = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          ROW_ACTIVE_LOW = 1'b0,
    parameter bit          COL_ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    glyph_matrix_scanner_if.slave bus
);

    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]          LAST_ROW   = 3'(NUM_ROWS - 1);
    // Pin levels that leave every LED dark.
    localparam logic [NUM_ROWS-1:0] ROW_OFF    = {NUM_ROWS{ROW_ACTIVE_LOW}};
    localparam logic [COL_W-1:0]    COL_OFF    = {COL_W{COL_ACTIVE_LOW}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          row_q, row_d;
    logic [GLYPH_W-1:0]  shadow_l_q, shadow_l_d;
    logic [GLYPH_W-1:0]  shadow_r_q, shadow_r_d;
    logic [NUM_ROWS-1:0] row_sel_q, row_sel_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                frame_start_q, frame_start_d;

    logic [GLYPH_COLS-1:0] cols_l, cols_r;

    // Whenever the next state is ON, row and shadow do not change on that edge,
    // so the current values select the columns that get registered.
    glyph_row_select u_row_l (
        .glyph (shadow_l_q),
        .row   (row_q),
        .cols  (cols_l)
    );

    glyph_row_select u_row_r (
        .glyph (shadow_r_q),
        .row   (row_q),
        .cols  (cols_r)
    );

    // State, counters, shadow glyphs and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            row_q         <= '0;
            shadow_l_q    <= '0;
            shadow_r_q    <= '0;
            row_sel_q     <= ROW_OFF;
            col_q         <= COL_OFF;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            shadow_l_q    <= shadow_l_d;
            shadow_r_q    <= shadow_r_d;
            row_sel_q     <= row_sel_d;
            col_q         <= col_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Scan sequencing and next output values.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_d         = row_q;
        shadow_l_d    = shadow_l_q;
        shadow_r_d    = shadow_r_q;
        frame_start_d = 1'b0;

        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            row_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d       = BLANK;
                    cnt_d         = '0;
                    row_d         = '0;
                    shadow_l_d    = bus.letter_left;
                    shadow_r_d    = bus.letter_right;
                    frame_start_d = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ON: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (row_q == LAST_ROW) begin
                            // new frame: fresh capture so the image never tears
                            row_d         = '0;
                            shadow_l_d    = bus.letter_left;
                            shadow_r_d    = bus.letter_right;
                            frame_start_d = 1'b1;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            endcase
        end

        row_sel_d = ROW_OFF;
        col_d     = COL_OFF;
        if (state_d == ON) begin
            row_sel_d = row_onehot(row_q) ^ ROW_OFF;
            col_d     = {cols_r, 1'b0, cols_l} ^ COL_OFF;
        end
    end

    assign bus.row_sel     = row_sel_q;
    assign bus.col         = col_q;
    assign bus.frame_start = frame_start_q;

endmodule
